// File: rtl/pipeline_stage_regs.sv
// Pipeline register bank for the IF/ID, ID/EX and EX/MEM boundaries of the core.
// Every output is a flop. Reset takes priority over hold, hold over flush, and flush
// over normal capture.
module pipeline_stage_regs #(
  parameter int unsigned         XLEN      = 32,
  parameter logic [XLEN-1:0]     NOP_INSTR = 32'h00000013
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            HOLD,
  input  logic            FLUSH,
  // IF -> ID
  input  logic [XLEN-1:0] IF_PC,
  input  logic [XLEN-1:0] IF_INSTRUCTION,
  output logic [XLEN-1:0] ID_PC,
  output logic [XLEN-1:0] ID_INSTRUCTION,
  // ID -> EX
  input  logic [XLEN-1:0] ID_PC_IN,
  input  logic [XLEN-1:0] ID_REG_DATA1,
  input  logic [XLEN-1:0] ID_REG_DATA2,
  input  logic [XLEN-1:0] ID_IMMEDIATE,
  input  logic [4:0]      ID_REG_WRITE_ADDR,
  input  logic [4:0]      ID_ALU_SELECT,
  input  logic            ID_OPERAND1_SELECT,
  input  logic            ID_OPERAND2_SELECT,
  input  logic            ID_REG_WRITE_EN,
  input  logic [2:0]      ID_DATA_MEM_WRITE,
  input  logic [3:0]      ID_DATA_MEM_READ,
  input  logic [3:0]      ID_BRANCH_CTRL,
  input  logic [1:0]      ID_WB_VALUE_SELECT,
  output logic [XLEN-1:0] EX_PC,
  output logic [XLEN-1:0] EX_REG_DATA1,
  output logic [XLEN-1:0] EX_REG_DATA2,
  output logic [XLEN-1:0] EX_IMMEDIATE,
  output logic [4:0]      EX_REG_WRITE_ADDR,
  output logic [4:0]      EX_ALU_SELECT,
  output logic            EX_OPERAND1_SELECT,
  output logic            EX_OPERAND2_SELECT,
  output logic            EX_REG_WRITE_EN,
  output logic [2:0]      EX_DATA_MEM_WRITE,
  output logic [3:0]      EX_DATA_MEM_READ,
  output logic [3:0]      EX_BRANCH_CTRL,
  output logic [1:0]      EX_WB_VALUE_SELECT,
  // EX -> MEM
  input  logic [XLEN-1:0] EX_PC_IN,
  input  logic [XLEN-1:0] EX_ALU_OUT,
  input  logic [XLEN-1:0] EX_REG_DATA2_IN,
  input  logic [4:0]      EX_REG_WRITE_ADDR_IN,
  input  logic            EX_REG_WRITE_EN_IN,
  input  logic [2:0]      EX_DATA_MEM_WRITE_IN,
  input  logic [3:0]      EX_DATA_MEM_READ_IN,
  input  logic [1:0]      EX_WB_VALUE_SELECT_IN,
  output logic [XLEN-1:0] MEM_PC,
  output logic [XLEN-1:0] MEM_ALU_OUT,
  output logic [XLEN-1:0] MEM_REG_DATA2,
  output logic [4:0]      MEM_REG_WRITE_ADDR,
  output logic            MEM_REG_WRITE_EN,
  output logic [2:0]      MEM_DATA_MEM_WRITE,
  output logic [3:0]      MEM_DATA_MEM_READ,
  output logic [1:0]      MEM_WB_VALUE_SELECT
);

  // IF/ID state
  logic [XLEN-1:0] id_pc_d, id_pc_q;
  logic [XLEN-1:0] id_instr_d, id_instr_q;

  // ID/EX state
  logic [XLEN-1:0] ex_pc_d, ex_pc_q;
  logic [XLEN-1:0] ex_rd1_d, ex_rd1_q;
  logic [XLEN-1:0] ex_rd2_d, ex_rd2_q;
  logic [XLEN-1:0] ex_imm_d, ex_imm_q;
  logic [4:0]      ex_wr_addr_d, ex_wr_addr_q;
  logic [4:0]      ex_alu_sel_d, ex_alu_sel_q;
  logic            ex_op1_sel_d, ex_op1_sel_q;
  logic            ex_op2_sel_d, ex_op2_sel_q;
  logic            ex_wr_en_d, ex_wr_en_q;
  logic [2:0]      ex_mem_wr_d, ex_mem_wr_q;
  logic [3:0]      ex_mem_rd_d, ex_mem_rd_q;
  logic [3:0]      ex_br_ctrl_d, ex_br_ctrl_q;
  logic [1:0]      ex_wb_sel_d, ex_wb_sel_q;

  // EX/MEM state
  logic [XLEN-1:0] mem_pc_d, mem_pc_q;
  logic [XLEN-1:0] mem_alu_d, mem_alu_q;
  logic [XLEN-1:0] mem_rd2_d, mem_rd2_q;
  logic [4:0]      mem_wr_addr_d, mem_wr_addr_q;
  logic            mem_wr_en_d, mem_wr_en_q;
  logic [2:0]      mem_mem_wr_d, mem_mem_wr_q;
  logic [3:0]      mem_mem_rd_d, mem_mem_rd_q;
  logic [1:0]      mem_wb_sel_d, mem_wb_sel_q;

  // IF/ID next state: a flush keeps the fetch PC but replaces the instruction with a NOP.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (RESET) begin
      id_pc_d    = '0;
      id_instr_d = '0;
    end else if (!HOLD) begin
      id_pc_d    = IF_PC;
      id_instr_d = FLUSH ? NOP_INSTR : IF_INSTRUCTION;
    end
  end

  // ID/EX next state: a flush turns the slot into an all-zero bubble.
  always_comb begin
    ex_pc_d      = ex_pc_q;
    ex_rd1_d     = ex_rd1_q;
    ex_rd2_d     = ex_rd2_q;
    ex_imm_d     = ex_imm_q;
    ex_wr_addr_d = ex_wr_addr_q;
    ex_alu_sel_d = ex_alu_sel_q;
    ex_op1_sel_d = ex_op1_sel_q;
    ex_op2_sel_d = ex_op2_sel_q;
    ex_wr_en_d   = ex_wr_en_q;
    ex_mem_wr_d  = ex_mem_wr_q;
    ex_mem_rd_d  = ex_mem_rd_q;
    ex_br_ctrl_d = ex_br_ctrl_q;
    ex_wb_sel_d  = ex_wb_sel_q;
    if (RESET || (!HOLD && FLUSH)) begin
      ex_pc_d      = '0;
      ex_rd1_d     = '0;
      ex_rd2_d     = '0;
      ex_imm_d     = '0;
      ex_wr_addr_d = '0;
      ex_alu_sel_d = '0;
      ex_op1_sel_d = 1'b0;
      ex_op2_sel_d = 1'b0;
      ex_wr_en_d   = 1'b0;
      ex_mem_wr_d  = '0;
      ex_mem_rd_d  = '0;
      ex_br_ctrl_d = '0;
      ex_wb_sel_d  = '0;
    end else if (!HOLD) begin
      ex_pc_d      = ID_PC_IN;
      ex_rd1_d     = ID_REG_DATA1;
      ex_rd2_d     = ID_REG_DATA2;
      ex_imm_d     = ID_IMMEDIATE;
      ex_wr_addr_d = ID_REG_WRITE_ADDR;
      ex_alu_sel_d = ID_ALU_SELECT;
      ex_op1_sel_d = ID_OPERAND1_SELECT;
      ex_op2_sel_d = ID_OPERAND2_SELECT;
      ex_wr_en_d   = ID_REG_WRITE_EN;
      ex_mem_wr_d  = ID_DATA_MEM_WRITE;
      ex_mem_rd_d  = ID_DATA_MEM_READ;
      ex_br_ctrl_d = ID_BRANCH_CTRL;
      ex_wb_sel_d  = ID_WB_VALUE_SELECT;
    end
  end

  // EX/MEM next state: unaffected by flush so the redirecting branch/jump still retires.
  always_comb begin
    mem_pc_d      = mem_pc_q;
    mem_alu_d     = mem_alu_q;
    mem_rd2_d     = mem_rd2_q;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_mem_wr_d  = mem_mem_wr_q;
    mem_mem_rd_d  = mem_mem_rd_q;
    mem_wb_sel_d  = mem_wb_sel_q;
    if (RESET) begin
      mem_pc_d      = '0;
      mem_alu_d     = '0;
      mem_rd2_d     = '0;
      mem_wr_addr_d = '0;
      mem_wr_en_d   = 1'b0;
      mem_mem_wr_d  = '0;
      mem_mem_rd_d  = '0;
      mem_wb_sel_d  = '0;
    end else if (!HOLD) begin
      mem_pc_d      = EX_PC_IN;
      mem_alu_d     = EX_ALU_OUT;
      mem_rd2_d     = EX_REG_DATA2_IN;
      mem_wr_addr_d = EX_REG_WRITE_ADDR_IN;
      mem_wr_en_d   = EX_REG_WRITE_EN_IN;
      mem_mem_wr_d  = EX_DATA_MEM_WRITE_IN;
      mem_mem_rd_d  = EX_DATA_MEM_READ_IN;
      mem_wb_sel_d  = EX_WB_VALUE_SELECT_IN;
    end
  end

  // State update; reset is folded into the next-state logic, so it is synchronous.
  always_ff @(posedge CLK) begin
    id_pc_q       <= id_pc_d;
    id_instr_q    <= id_instr_d;
    ex_pc_q       <= ex_pc_d;
    ex_rd1_q      <= ex_rd1_d;
    ex_rd2_q      <= ex_rd2_d;
    ex_imm_q      <= ex_imm_d;
    ex_wr_addr_q  <= ex_wr_addr_d;
    ex_alu_sel_q  <= ex_alu_sel_d;
    ex_op1_sel_q  <= ex_op1_sel_d;
    ex_op2_sel_q  <= ex_op2_sel_d;
    ex_wr_en_q    <= ex_wr_en_d;
    ex_mem_wr_q   <= ex_mem_wr_d;
    ex_mem_rd_q   <= ex_mem_rd_d;
    ex_br_ctrl_q  <= ex_br_ctrl_d;
    ex_wb_sel_q   <= ex_wb_sel_d;
    mem_pc_q      <= mem_pc_d;
    mem_alu_q     <= mem_alu_d;
    mem_rd2_q     <= mem_rd2_d;
    mem_wr_addr_q <= mem_wr_addr_d;
    mem_wr_en_q   <= mem_wr_en_d;
    mem_mem_wr_q  <= mem_mem_wr_d;
    mem_mem_rd_q  <= mem_mem_rd_d;
    mem_wb_sel_q  <= mem_wb_sel_d;
  end

  assign ID_PC               = id_pc_q;
  assign ID_INSTRUCTION      = id_instr_q;
  assign EX_PC               = ex_pc_q;
  assign EX_REG_DATA1        = ex_rd1_q;
  assign EX_REG_DATA2        = ex_rd2_q;
  assign EX_IMMEDIATE        = ex_imm_q;
  assign EX_REG_WRITE_ADDR   = ex_wr_addr_q;
  assign EX_ALU_SELECT       = ex_alu_sel_q;
  assign EX_OPERAND1_SELECT  = ex_op1_sel_q;
  assign EX_OPERAND2_SELECT  = ex_op2_sel_q;
  assign EX_REG_WRITE_EN     = ex_wr_en_q;
  assign EX_DATA_MEM_WRITE   = ex_mem_wr_q;
  assign EX_DATA_MEM_READ    = ex_mem_rd_q;
  assign EX_BRANCH_CTRL      = ex_br_ctrl_q;
  assign EX_WB_VALUE_SELECT  = ex_wb_sel_q;
  assign MEM_PC              = mem_pc_q;
  assign MEM_ALU_OUT         = mem_alu_q;
  assign MEM_REG_DATA2       = mem_rd2_q;
  assign MEM_REG_WRITE_ADDR  = mem_wr_addr_q;
  assign MEM_REG_WRITE_EN    = mem_wr_en_q;
  assign MEM_DATA_MEM_WRITE  = mem_mem_wr_q;
  assign MEM_DATA_MEM_READ   = mem_mem_rd_q;
  assign MEM_WB_VALUE_SELECT = mem_wb_sel_q;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed bench for pipeline_stage_regs: reset, normal flow, hold, flush, hold+flush,
// and reset overriding hold/flush.
module tb_pipeline_stage_regs;

  logic        CLK = 1'b0;
  logic        RESET, HOLD, FLUSH;
  logic [31:0] IF_PC, IF_INSTRUCTION, ID_PC, ID_INSTRUCTION;
  logic [31:0] ID_PC_IN, ID_REG_DATA1, ID_REG_DATA2, ID_IMMEDIATE;
  logic [4:0]  ID_REG_WRITE_ADDR, ID_ALU_SELECT;
  logic        ID_OPERAND1_SELECT, ID_OPERAND2_SELECT, ID_REG_WRITE_EN;
  logic [2:0]  ID_DATA_MEM_WRITE;
  logic [3:0]  ID_DATA_MEM_READ, ID_BRANCH_CTRL;
  logic [1:0]  ID_WB_VALUE_SELECT;
  logic [31:0] EX_PC, EX_REG_DATA1, EX_REG_DATA2, EX_IMMEDIATE;
  logic [4:0]  EX_REG_WRITE_ADDR, EX_ALU_SELECT;
  logic        EX_OPERAND1_SELECT, EX_OPERAND2_SELECT, EX_REG_WRITE_EN;
  logic [2:0]  EX_DATA_MEM_WRITE;
  logic [3:0]  EX_DATA_MEM_READ, EX_BRANCH_CTRL;
  logic [1:0]  EX_WB_VALUE_SELECT;
  logic [31:0] EX_PC_IN, EX_ALU_OUT, EX_REG_DATA2_IN;
  logic [4:0]  EX_REG_WRITE_ADDR_IN;
  logic        EX_REG_WRITE_EN_IN;
  logic [2:0]  EX_DATA_MEM_WRITE_IN;
  logic [3:0]  EX_DATA_MEM_READ_IN;
  logic [1:0]  EX_WB_VALUE_SELECT_IN;
  logic [31:0] MEM_PC, MEM_ALU_OUT, MEM_REG_DATA2;
  logic [4:0]  MEM_REG_WRITE_ADDR;
  logic        MEM_REG_WRITE_EN;
  logic [2:0]  MEM_DATA_MEM_WRITE;
  logic [3:0]  MEM_DATA_MEM_READ;
  logic [1:0]  MEM_WB_VALUE_SELECT;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_stage_regs dut (
    .CLK(CLK), .RESET(RESET), .HOLD(HOLD), .FLUSH(FLUSH),
    .IF_PC(IF_PC), .IF_INSTRUCTION(IF_INSTRUCTION),
    .ID_PC(ID_PC), .ID_INSTRUCTION(ID_INSTRUCTION),
    .ID_PC_IN(ID_PC_IN), .ID_REG_DATA1(ID_REG_DATA1), .ID_REG_DATA2(ID_REG_DATA2),
    .ID_IMMEDIATE(ID_IMMEDIATE), .ID_REG_WRITE_ADDR(ID_REG_WRITE_ADDR),
    .ID_ALU_SELECT(ID_ALU_SELECT), .ID_OPERAND1_SELECT(ID_OPERAND1_SELECT),
    .ID_OPERAND2_SELECT(ID_OPERAND2_SELECT), .ID_REG_WRITE_EN(ID_REG_WRITE_EN),
    .ID_DATA_MEM_WRITE(ID_DATA_MEM_WRITE), .ID_DATA_MEM_READ(ID_DATA_MEM_READ),
    .ID_BRANCH_CTRL(ID_BRANCH_CTRL), .ID_WB_VALUE_SELECT(ID_WB_VALUE_SELECT),
    .EX_PC(EX_PC), .EX_REG_DATA1(EX_REG_DATA1), .EX_REG_DATA2(EX_REG_DATA2),
    .EX_IMMEDIATE(EX_IMMEDIATE), .EX_REG_WRITE_ADDR(EX_REG_WRITE_ADDR),
    .EX_ALU_SELECT(EX_ALU_SELECT), .EX_OPERAND1_SELECT(EX_OPERAND1_SELECT),
    .EX_OPERAND2_SELECT(EX_OPERAND2_SELECT), .EX_REG_WRITE_EN(EX_REG_WRITE_EN),
    .EX_DATA_MEM_WRITE(EX_DATA_MEM_WRITE), .EX_DATA_MEM_READ(EX_DATA_MEM_READ),
    .EX_BRANCH_CTRL(EX_BRANCH_CTRL), .EX_WB_VALUE_SELECT(EX_WB_VALUE_SELECT),
    .EX_PC_IN(EX_PC_IN), .EX_ALU_OUT(EX_ALU_OUT), .EX_REG_DATA2_IN(EX_REG_DATA2_IN),
    .EX_REG_WRITE_ADDR_IN(EX_REG_WRITE_ADDR_IN), .EX_REG_WRITE_EN_IN(EX_REG_WRITE_EN_IN),
    .EX_DATA_MEM_WRITE_IN(EX_DATA_MEM_WRITE_IN), .EX_DATA_MEM_READ_IN(EX_DATA_MEM_READ_IN),
    .EX_WB_VALUE_SELECT_IN(EX_WB_VALUE_SELECT_IN),
    .MEM_PC(MEM_PC), .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_REG_DATA2(MEM_REG_DATA2),
    .MEM_REG_WRITE_ADDR(MEM_REG_WRITE_ADDR), .MEM_REG_WRITE_EN(MEM_REG_WRITE_EN),
    .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE), .MEM_DATA_MEM_READ(MEM_DATA_MEM_READ),
    .MEM_WB_VALUE_SELECT(MEM_WB_VALUE_SELECT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ID_PC"}, ID_PC, 32'h0);
    check({tag, " ID_INSTRUCTION"}, ID_INSTRUCTION, 32'h0);
    check({tag, " EX_PC"}, EX_PC, 32'h0);
    check({tag, " EX_REG_DATA1"}, EX_REG_DATA1, 32'h0);
    check({tag, " EX_REG_DATA2"}, EX_REG_DATA2, 32'h0);
    check({tag, " EX_IMMEDIATE"}, EX_IMMEDIATE, 32'h0);
    check({tag, " EX_REG_WRITE_ADDR"}, 32'(EX_REG_WRITE_ADDR), 32'h0);
    check({tag, " EX_ALU_SELECT"}, 32'(EX_ALU_SELECT), 32'h0);
    check({tag, " EX_OP_SELS"}, {30'h0, EX_OPERAND1_SELECT, EX_OPERAND2_SELECT}, 32'h0);
    check({tag, " EX_REG_WRITE_EN"}, 32'(EX_REG_WRITE_EN), 32'h0);
    check({tag, " EX_DATA_MEM_WRITE"}, 32'(EX_DATA_MEM_WRITE), 32'h0);
    check({tag, " EX_DATA_MEM_READ"}, 32'(EX_DATA_MEM_READ), 32'h0);
    check({tag, " EX_BRANCH_CTRL"}, 32'(EX_BRANCH_CTRL), 32'h0);
    check({tag, " EX_WB_VALUE_SELECT"}, 32'(EX_WB_VALUE_SELECT), 32'h0);
    check({tag, " MEM_PC"}, MEM_PC, 32'h0);
    check({tag, " MEM_ALU_OUT"}, MEM_ALU_OUT, 32'h0);
    check({tag, " MEM_REG_DATA2"}, MEM_REG_DATA2, 32'h0);
    check({tag, " MEM_REG_WRITE_ADDR"}, 32'(MEM_REG_WRITE_ADDR), 32'h0);
    check({tag, " MEM_REG_WRITE_EN"}, 32'(MEM_REG_WRITE_EN), 32'h0);
    check({tag, " MEM_DATA_MEM_WRITE"}, 32'(MEM_DATA_MEM_WRITE), 32'h0);
    check({tag, " MEM_DATA_MEM_READ"}, 32'(MEM_DATA_MEM_READ), 32'h0);
    check({tag, " MEM_WB_VALUE_SELECT"}, 32'(MEM_WB_VALUE_SELECT), 32'h0);
  endtask

  initial begin
    // Reset with random inputs for two edges.
    RESET = 1'b1; HOLD = 1'b0; FLUSH = 1'b0;
    IF_PC = $urandom; IF_INSTRUCTION = $urandom;
    ID_PC_IN = $urandom; ID_REG_DATA1 = $urandom; ID_REG_DATA2 = $urandom;
    ID_IMMEDIATE = $urandom; ID_REG_WRITE_ADDR = 5'($urandom); ID_ALU_SELECT = 5'($urandom);
    ID_OPERAND1_SELECT = 1'b1; ID_OPERAND2_SELECT = 1'b1; ID_REG_WRITE_EN = 1'b1;
    ID_DATA_MEM_WRITE = 3'b100; ID_DATA_MEM_READ = 4'b1000; ID_BRANCH_CTRL = 4'($urandom);
    ID_WB_VALUE_SELECT = 2'b11;
    EX_PC_IN = $urandom; EX_ALU_OUT = $urandom; EX_REG_DATA2_IN = $urandom;
    EX_REG_WRITE_ADDR_IN = 5'($urandom); EX_REG_WRITE_EN_IN = 1'b1;
    EX_DATA_MEM_WRITE_IN = 3'b100; EX_DATA_MEM_READ_IN = 4'b1010; EX_WB_VALUE_SELECT_IN = 2'b10;
    tick();
    check_all_zero("reset1");
    tick();
    check_all_zero("reset2");

    // Normal flow, stage 1: IF values into IF/ID.
    RESET = 1'b0;
    IF_PC = 32'h40; IF_INSTRUCTION = 32'h00A00093;
    tick();
    check("n ID_PC", ID_PC, 32'h40);
    check("n ID_INSTRUCTION", ID_INSTRUCTION, 32'h00A00093);

    // Stage 2: decode values into ID/EX; next instruction enters IF/ID.
    ID_PC_IN = 32'h40; ID_REG_DATA1 = 32'h11; ID_REG_DATA2 = 32'h22; ID_IMMEDIATE = 32'd10;
    ID_REG_WRITE_ADDR = 5'd1; ID_ALU_SELECT = 5'h03; ID_OPERAND1_SELECT = 1'b1;
    ID_OPERAND2_SELECT = 1'b0; ID_REG_WRITE_EN = 1'b1; ID_DATA_MEM_WRITE = 3'b010;
    ID_DATA_MEM_READ = 4'b0100; ID_BRANCH_CTRL = 4'b0010; ID_WB_VALUE_SELECT = 2'b10;
    IF_PC = 32'h44; IF_INSTRUCTION = 32'h00100113;
    tick();
    check("n1 ID_PC", ID_PC, 32'h44);
    check("n1 EX_PC", EX_PC, 32'h40);
    check("n1 EX_REG_DATA1", EX_REG_DATA1, 32'h11);
    check("n1 EX_REG_DATA2", EX_REG_DATA2, 32'h22);
    check("n1 EX_IMMEDIATE", EX_IMMEDIATE, 32'd10);
    check("n1 EX_REG_WRITE_ADDR", 32'(EX_REG_WRITE_ADDR), 32'd1);
    check("n1 EX_ALU_SELECT", 32'(EX_ALU_SELECT), 32'h03);
    check("n1 EX_OP_SELS", {30'h0, EX_OPERAND1_SELECT, EX_OPERAND2_SELECT}, 32'b10);
    check("n1 EX_REG_WRITE_EN", 32'(EX_REG_WRITE_EN), 32'd1);
    check("n1 EX_DATA_MEM_WRITE", 32'(EX_DATA_MEM_WRITE), 32'b010);
    check("n1 EX_DATA_MEM_READ", 32'(EX_DATA_MEM_READ), 32'b0100);
    check("n1 EX_BRANCH_CTRL", 32'(EX_BRANCH_CTRL), 32'b0010);
    check("n1 EX_WB_VALUE_SELECT", 32'(EX_WB_VALUE_SELECT), 32'b10);

    // Stage 3: EX results into EX/MEM; second instruction into ID/EX.
    EX_PC_IN = 32'h40; EX_ALU_OUT = 32'd10; EX_REG_DATA2_IN = 32'h1234;
    EX_REG_WRITE_ADDR_IN = 5'd1; EX_REG_WRITE_EN_IN = 1'b1; EX_DATA_MEM_WRITE_IN = 3'b001;
    EX_DATA_MEM_READ_IN = 4'b0011; EX_WB_VALUE_SELECT_IN = 2'b01;
    ID_PC_IN = 32'h44; ID_IMMEDIATE = 32'd1; ID_REG_WRITE_ADDR = 5'd2;
    tick();
    check("n2 MEM_PC", MEM_PC, 32'h40);
    check("n2 MEM_ALU_OUT", MEM_ALU_OUT, 32'd10);
    check("n2 MEM_REG_DATA2", MEM_REG_DATA2, 32'h1234);
    check("n2 MEM_REG_WRITE_ADDR", 32'(MEM_REG_WRITE_ADDR), 32'd1);
    check("n2 MEM_REG_WRITE_EN", 32'(MEM_REG_WRITE_EN), 32'd1);
    check("n2 MEM_DATA_MEM_WRITE", 32'(MEM_DATA_MEM_WRITE), 32'b001);
    check("n2 MEM_DATA_MEM_READ", 32'(MEM_DATA_MEM_READ), 32'b0011);
    check("n2 MEM_WB_VALUE_SELECT", 32'(MEM_WB_VALUE_SELECT), 32'b01);
    check("n2 EX_IMMEDIATE", EX_IMMEDIATE, 32'd1);
    check("n2 EX_REG_WRITE_ADDR", 32'(EX_REG_WRITE_ADDR), 32'd2);
    check("n2 ID_INSTRUCTION", ID_INSTRUCTION, 32'h00100113);

    // Hold for three edges while every stage's inputs change.
    HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IF_PC = 32'h44 + 32'(4 * i); IF_INSTRUCTION = 32'hABC00000 + 32'(i);
      ID_PC_IN = 32'h100 + 32'(i); ID_IMMEDIATE = 32'h200 + 32'(i);
      EX_ALU_OUT = 32'h300 + 32'(i);
      tick();
      check("hold ID_PC", ID_PC, 32'h44);
      check("hold ID_INSTRUCTION", ID_INSTRUCTION, 32'h00100113);
      check("hold EX_PC", EX_PC, 32'h44);
      check("hold EX_IMMEDIATE", EX_IMMEDIATE, 32'd1);
      check("hold MEM_ALU_OUT", MEM_ALU_OUT, 32'd10);
    end

    // Release: capture resumes with the current inputs.
    HOLD = 1'b0;
    IF_PC = 32'h4C; IF_INSTRUCTION = 32'h00208193;
    ID_IMMEDIATE = 32'd2; EX_ALU_OUT = 32'd11;
    tick();
    check("rel ID_PC", ID_PC, 32'h4C);
    check("rel ID_INSTRUCTION", ID_INSTRUCTION, 32'h00208193);
    check("rel EX_IMMEDIATE", EX_IMMEDIATE, 32'd2);
    check("rel EX_PC", EX_PC, 32'h102);
    check("rel MEM_ALU_OUT", MEM_ALU_OUT, 32'd11);

    // Flush: IF/ID gets NOP, ID/EX becomes a bubble, EX/MEM captures normally.
    FLUSH = 1'b1;
    IF_PC = 32'h60; IF_INSTRUCTION = 32'h12345678;
    ID_PC_IN = 32'h50; ID_REG_WRITE_EN = 1'b1; ID_DATA_MEM_WRITE = 3'b100;
    ID_DATA_MEM_READ = 4'b1000; ID_BRANCH_CTRL = 4'b1000; ID_IMMEDIATE = 32'h55;
    EX_ALU_OUT = 32'h80;
    tick();
    check("fl ID_PC", ID_PC, 32'h60);
    check("fl ID_INSTRUCTION", ID_INSTRUCTION, 32'h00000013);
    check("fl EX_REG_WRITE_EN", 32'(EX_REG_WRITE_EN), 32'd0);
    check("fl EX_DATA_MEM_WRITE", 32'(EX_DATA_MEM_WRITE), 32'd0);
    check("fl EX_DATA_MEM_READ", 32'(EX_DATA_MEM_READ), 32'd0);
    check("fl EX_BRANCH_CTRL", 32'(EX_BRANCH_CTRL), 32'd0);
    check("fl EX_PC", EX_PC, 32'h0);
    check("fl EX_IMMEDIATE", EX_IMMEDIATE, 32'h0);
    check("fl EX_REG_DATA1", EX_REG_DATA1, 32'h0);
    check("fl MEM_ALU_OUT", MEM_ALU_OUT, 32'h80);
    check("fl MEM_REG_WRITE_EN", 32'(MEM_REG_WRITE_EN), 32'd1);

    // Refill normally.
    FLUSH = 1'b0;
    IF_PC = 32'h64; IF_INSTRUCTION = 32'h00500293;
    ID_PC_IN = 32'h60; ID_IMMEDIATE = 32'd5; ID_BRANCH_CTRL = 4'b0001;
    ID_DATA_MEM_WRITE = 3'b000; ID_DATA_MEM_READ = 4'b0000;
    EX_ALU_OUT = 32'h90;
    tick();
    check("rf ID_INSTRUCTION", ID_INSTRUCTION, 32'h00500293);
    check("rf EX_BRANCH_CTRL", 32'(EX_BRANCH_CTRL), 32'b0001);
    check("rf EX_REG_WRITE_EN", 32'(EX_REG_WRITE_EN), 32'd1);

    // Flush and hold together: nothing changes while held.
    FLUSH = 1'b1; HOLD = 1'b1;
    IF_PC = 32'h68; IF_INSTRUCTION = 32'hDEADBEEF;
    ID_PC_IN = 32'h64; ID_IMMEDIATE = 32'd7; EX_ALU_OUT = 32'hA0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("fh ID_PC", ID_PC, 32'h64);
      check("fh ID_INSTRUCTION", ID_INSTRUCTION, 32'h00500293);
      check("fh EX_BRANCH_CTRL", 32'(EX_BRANCH_CTRL), 32'b0001);
      check("fh EX_IMMEDIATE", EX_IMMEDIATE, 32'd5);
      check("fh MEM_ALU_OUT", MEM_ALU_OUT, 32'h90);
    end

    // Release hold with flush still asserted: flush lands on this edge.
    HOLD = 1'b0;
    tick();
    check("fr ID_PC", ID_PC, 32'h68);
    check("fr ID_INSTRUCTION", ID_INSTRUCTION, 32'h00000013);
    check("fr EX_BRANCH_CTRL", 32'(EX_BRANCH_CTRL), 32'd0);
    check("fr EX_IMMEDIATE", EX_IMMEDIATE, 32'd0);
    check("fr EX_REG_WRITE_EN", 32'(EX_REG_WRITE_EN), 32'd0);
    check("fr MEM_ALU_OUT", MEM_ALU_OUT, 32'hA0);

    // Repopulate, then reset while hold and flush are both asserted.
    FLUSH = 1'b0;
    EX_DATA_MEM_READ_IN = 4'b1010;
    tick();
    check("pre EX_REG_WRITE_EN", 32'(EX_REG_WRITE_EN), 32'd1);
    check("pre ID_INSTRUCTION", ID_INSTRUCTION, 32'hDEADBEEF);
    check("pre MEM_DATA_MEM_READ", 32'(MEM_DATA_MEM_READ), 32'b1010);
    RESET = 1'b1; HOLD = 1'b1; FLUSH = 1'b1;
    tick();
    check_all_zero("rst_hf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_regs.md
Name: pipeline_stage_regs

Overview:
Front-end pipeline register bank for the 5-stage RV32IM core. Holds the IF/ID, ID/EX and EX/MEM boundaries in one block. Each boundary captures the upstream stage's datapath and control values on the rising clock edge and presents them to the next stage. Global HOLD (cache busywait) and branch FLUSH controls are included; MEM/WB stays a separate register.

Parameters:
XLEN, 32, datapath width (PC, instruction, operands, immediate, ALU result).
NOP_INSTR, 32'h00000013, instruction word inserted into IF/ID on flush (addi x0,x0,0).

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  synchronous, active-high; clears every register
HOLD  input  1  stall: all three boundaries keep their contents (instr/data cache busywait)
FLUSH  input  1  taken branch/jump from EX: bubble IF/ID and ID/EX
IF_PC, IF_INSTRUCTION  input  XLEN each  fetch-stage PC and instruction
ID_PC, ID_INSTRUCTION  output  XLEN each  registered IF values
ID_PC_IN, ID_REG_DATA1, ID_REG_DATA2, ID_IMMEDIATE  input  XLEN each  decode values (ID_PC_IN driven from ID_PC externally)
ID_REG_WRITE_ADDR  input  5  rd (instruction[11:7])
ID_ALU_SELECT  input  5; ID_OPERAND1_SELECT, ID_OPERAND2_SELECT, ID_REG_WRITE_EN  input  1 each
ID_DATA_MEM_WRITE  input  3; ID_DATA_MEM_READ  input  4; ID_BRANCH_CTRL  input  4; ID_WB_VALUE_SELECT  input  2
EX_PC, EX_REG_DATA1, EX_REG_DATA2, EX_IMMEDIATE  output  XLEN each; EX_REG_WRITE_ADDR  output  5
EX_ALU_SELECT  output  5; EX_OPERAND1_SELECT, EX_OPERAND2_SELECT, EX_REG_WRITE_EN  output  1 each
EX_DATA_MEM_WRITE  output  3; EX_DATA_MEM_READ  output  4; EX_BRANCH_CTRL  output  4; EX_WB_VALUE_SELECT  output  2
EX_PC_IN, EX_ALU_OUT, EX_REG_DATA2_IN  input  XLEN each; EX_REG_WRITE_ADDR_IN  input  5; EX_REG_WRITE_EN_IN  input  1
EX_DATA_MEM_WRITE_IN  input  3; EX_DATA_MEM_READ_IN  input  4; EX_WB_VALUE_SELECT_IN  input  2
MEM_PC, MEM_ALU_OUT, MEM_REG_DATA2  output  XLEN each; MEM_REG_WRITE_ADDR  output  5; MEM_REG_WRITE_EN  output  1
MEM_DATA_MEM_WRITE  output  3; MEM_DATA_MEM_READ  output  4; MEM_WB_VALUE_SELECT  output  2

Behaviour:
- All outputs are registered only; there are no combinational input-to-output paths. Latency is 1 cycle per boundary.
- Priority at each rising edge: RESET > HOLD > FLUSH > normal capture.
- RESET=1: every output becomes 0, including ID_INSTRUCTION=0, all enables=0 and all selects=0. This holds regardless of HOLD/FLUSH.
- HOLD=1 (RESET=0): all three boundaries retain their values. FLUSH is ignored that cycle; because the EX stage is also held, FLUSH stays asserted and takes effect on the first non-held edge.
- FLUSH=1 (RESET=0, HOLD=0):
  - IF/ID: ID_PC <= IF_PC, ID_INSTRUCTION <= NOP_INSTR.
  - ID/EX: every output <= 0. This makes it a bubble: no register write, no memory read/write, no branch.
  - EX/MEM captures normally, so the branch/jump instruction itself proceeds.
- Normal (RESET=0, HOLD=0, FLUSH=0): each output <= its corresponding input, bit-exact, with no width conversion.
- DATA_MEM_READ/WRITE encodings pass through untouched; bit 3 (read) and bit 2 (write) are the request flags consumed downstream.
- X on inputs is captured as-is; after RESET, outputs are fully defined.

Test Plan:
- RESET=1 for 2 edges with random inputs -> all outputs 0, ID_INSTRUCTION=0, EX_REG_WRITE_EN=0, MEM_DATA_MEM_READ=0.
- Normal flow: IF_PC=0x40, IF_INSTRUCTION=0x00A00093 at edge n -> ID_PC=0x40, ID_INSTRUCTION=0x00A00093 after edge n. Feed ID_* with ID_REG_WRITE_ADDR=1, ID_IMMEDIATE=10 -> EX_* match after edge n+1. Feed EX_* with ALU_OUT=10 -> MEM_ALU_OUT=10, MEM_REG_WRITE_ADDR=1 after edge n+2.
- HOLD=1 for 3 edges while inputs change (IF_PC 0x44->0x48->0x4C) -> all outputs frozen at their pre-hold values. Release -> capture resumes with current inputs.
- FLUSH=1 with HOLD=0, ID_REG_WRITE_EN=1, ID_DATA_MEM_WRITE=3'b100 -> ID_INSTRUCTION=0x00000013, EX_REG_WRITE_EN=0, EX_DATA_MEM_WRITE=0, EX_BRANCH_CTRL=0. EX/MEM captures EX_ALU_OUT=0x80 -> MEM_ALU_OUT=0x80.
- FLUSH=1 and HOLD=1 together for 2 edges, then HOLD=0 -> no change during hold; flush applied on the release edge.
- RESET asserted mid-stream while HOLD=1 and FLUSH=1 -> all outputs 0 on that edge.
